// File: rtl/reorder_pkg.sv
// Types and defaults shared between the reorder buffer write and read sides.
package reorder_pkg;

    localparam int DEPTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        WR0    = 3'b001,
        WR1    = 3'b010,
        WRWAIT = 3'b100
    } wr_state_t;

endpackage

// File: rtl/bank_tracker.sv
// Per-bank fill bitmap and lock: completion when the last free slot is written,
// release when the reader drains the final entry.
module bank_tracker
    import reorder_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [TAG_W-1:0] set_slot,
    input  logic             clr,
    output logic             slot_busy,
    output logic             complete,
    output logic             lock
);

    logic [DEPTH-1:0] bitmap;
    logic [DEPTH-1:0] slot_mask;
    logic [DEPTH-1:0] filled;

    assign slot_mask = {{(DEPTH-1){1'b0}}, 1'b1} << set_slot;
    assign filled    = bitmap | slot_mask;
    assign slot_busy = |(bitmap & slot_mask);
    assign complete  = set_en && (&filled);

    // Release wins over a write; the writer never targets a locked bank anyway.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bitmap <= '0;
            lock   <= 1'b0;
        end else if (clr) begin
            bitmap <= '0;
            lock   <= 1'b0;
        end else if (set_en) begin
            bitmap <= filled;
            if (complete) begin
                lock <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/wr_ctrl.sv
// Two-bank reorder write controller with shared read pointer.
// Optional duplicate-tag detection is enabled by defining WR_DUP_CHECK_EN.
module wr_ctrl
    import reorder_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [TAG_W-1:0] in_tag,
    output logic             in_rdy,
    output logic             wr_en,
    output logic [TAG_W:0]   wr_addr,
    input  logic             mem0rd_st_decode,
    input  logic             mem1rd_st_decode,
    input  logic             rd_en,
    output logic [TAG_W:0]   rd_addr,
    output logic             rd_fire,
    output logic             mem0_lock,
    output logic             mem1_lock,
    output logic             mem0_empty,
    output logic             mem1_empty,
    output logic             err_dup
);

    wr_state_t        state;
    wr_state_t        state_nxt;
    logic             next_bank;
    logic             next_bank_nxt;
    logic             cur_bank;
    logic             cur_lock;
    logic             accept;
    logic             dup;
    logic             set0;
    logic             set1;
    logic             busy0;
    logic             busy1;
    logic             complete0;
    logic             complete1;
    logic             rel0;
    logic             rel1;
    logic             hit0;
    logic             hit1;
    logic             ptr_last;
    logic [TAG_W-1:0] rd_ptr;

    assign cur_bank = (state == WR1);
    assign cur_lock = cur_bank ? mem1_lock : mem0_lock;
    assign in_rdy   = rst_n && (state != WRWAIT) && !cur_lock;
    assign accept   = in_vld && in_rdy;
    assign wr_en    = accept && !dup;
    assign wr_addr  = {cur_bank, in_tag};
    assign set0     = wr_en && !cur_bank;
    assign set1     = wr_en && cur_bank;

`ifdef WR_DUP_CHECK_EN
    logic err_dup_q;

    // A duplicate is consumed but never written; the flag follows one cycle later.
    assign dup = accept && (cur_bank ? busy1 : busy0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_dup_q <= 1'b0;
        end else begin
            err_dup_q <= dup;
        end
    end

    assign err_dup = err_dup_q;
`else
    logic unused_busy;

    assign dup         = 1'b0;
    assign err_dup     = 1'b0;
    assign unused_busy = busy0 ^ busy1;
`endif

    assign hit0       = mem0rd_st_decode && mem0_lock;
    assign hit1       = mem1rd_st_decode && mem1_lock;
    assign rd_fire    = rd_en && (hit0 || hit1);
    assign ptr_last   = (rd_ptr == TAG_W'(DEPTH - 1));
    assign rel0       = rd_en && hit0 && ptr_last;
    assign rel1       = rd_en && hit1 && ptr_last;
    assign rd_addr    = {mem1rd_st_decode, rd_ptr};
    assign mem0_empty = !mem0_lock;
    assign mem1_empty = !mem1_lock;

    bank_tracker #(.DEPTH(DEPTH)) u_bank0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (set0),
        .set_slot (in_tag),
        .clr      (rel0),
        .slot_busy(busy0),
        .complete (complete0),
        .lock     (mem0_lock)
    );

    bank_tracker #(.DEPTH(DEPTH)) u_bank1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (set1),
        .set_slot (in_tag),
        .clr      (rel1),
        .slot_busy(busy1),
        .complete (complete1),
        .lock     (mem1_lock)
    );

    // On completion, a bank releasing at the same edge counts as already free.
    always_comb begin
        state_nxt     = state;
        next_bank_nxt = next_bank;
        case (state)
            WR0: begin
                if (complete0) begin
                    next_bank_nxt = ~next_bank;
                    state_nxt     = (mem1_lock && !rel1) ? WRWAIT : WR1;
                end
            end
            WR1: begin
                if (complete1) begin
                    next_bank_nxt = ~next_bank;
                    state_nxt     = (mem0_lock && !rel0) ? WRWAIT : WR0;
                end
            end
            WRWAIT: begin
                if (!(next_bank ? mem1_lock : mem0_lock)) begin
                    state_nxt = next_bank ? WR1 : WR0;
                end
            end
            default: begin
                state_nxt     = WR0;
                next_bank_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= WR0;
            next_bank <= 1'b0;
        end else begin
            state     <= state_nxt;
            next_bank <= next_bank_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (rd_fire) begin
            rd_ptr <= rd_ptr + TAG_W'(1);
        end
    end

endmodule

// File: tb/tb_wr_ctrl.sv
// Directed bench for wr_ctrl with DEPTH=4; duplicate checks follow WR_DUP_CHECK_EN.
module tb_wr_ctrl;
    import reorder_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_vld;
    logic [TAG_W-1:0] in_tag;
    logic             in_rdy;
    logic             wr_en;
    logic [TAG_W:0]   wr_addr;
    logic             mem0rd_st_decode;
    logic             mem1rd_st_decode;
    logic             rd_en;
    logic [TAG_W:0]   rd_addr;
    logic             rd_fire;
    logic             mem0_lock;
    logic             mem1_lock;
    logic             mem0_empty;
    logic             mem1_empty;
    logic             err_dup;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wr_ctrl #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_vld          (in_vld),
        .in_tag          (in_tag),
        .in_rdy          (in_rdy),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .mem0rd_st_decode(mem0rd_st_decode),
        .mem1rd_st_decode(mem1rd_st_decode),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .rd_fire         (rd_fire),
        .mem0_lock       (mem0_lock),
        .mem1_lock       (mem1_lock),
        .mem0_empty      (mem0_empty),
        .mem1_empty      (mem1_empty),
        .err_dup         (err_dup)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [TAG_W-1:0] t, input logic [TAG_W:0] exp_addr);
        in_vld = 1'b1;
        in_tag = t;
        #1;
        chk("wr_en", 32'(wr_en), 32'd1);
        chk("wr_addr", 32'(wr_addr), 32'(exp_addr));
        tick();
        in_vld = 1'b0;
    endtask

    task automatic do_pop(input logic bank, input logic [TAG_W:0] exp_addr);
        rd_en            = 1'b1;
        mem0rd_st_decode = !bank;
        mem1rd_st_decode = bank;
        #1;
        chk("rd_fire", 32'(rd_fire), 32'd1);
        chk("rd_addr", 32'(rd_addr), 32'(exp_addr));
        tick();
        rd_en            = 1'b0;
        mem0rd_st_decode = 1'b0;
        mem1rd_st_decode = 1'b0;
    endtask

    initial begin
        rst_n            = 1'b0;
        in_vld           = 1'b1;
        in_tag           = '0;
        rd_en            = 1'b0;
        mem0rd_st_decode = 1'b0;
        mem1rd_st_decode = 1'b0;
        tick();
        tick();
        chk("rst_in_rdy", 32'(in_rdy), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        rst_n  = 1'b1;
        in_vld = 1'b0;
        tick();
        chk("init_state", 32'(dut.state), 32'(WR0));
        chk("init_lock0", 32'(mem0_lock), 32'd0);
        chk("init_lock1", 32'(mem1_lock), 32'd0);
        chk("init_empty0", 32'(mem0_empty), 32'd1);
        chk("init_empty1", 32'(mem1_empty), 32'd1);
        chk("init_err_dup", 32'(err_dup), 32'd0);
        chk("init_in_rdy", 32'(in_rdy), 32'd1);

        // Out-of-order fill of bank0
        do_write(2'd3, 3'd3);
        do_write(2'd1, 3'd1);
        do_write(2'd0, 3'd0);
        chk("b0_partial_lock", 32'(mem0_lock), 32'd0);
        do_write(2'd2, 3'd2);
        chk("b0_lock", 32'(mem0_lock), 32'd1);
        chk("b0_empty", 32'(mem0_empty), 32'd0);
        chk("b0_state_wr1", 32'(dut.state), 32'(WR1));

        // Pop request with no decode active
        rd_en = 1'b1;
        #1;
        chk("nodec_rd_fire", 32'(rd_fire), 32'd0);
        tick();
        chk("nodec_rd_ptr", 32'(dut.rd_ptr), 32'd0);
        rd_en = 1'b0;

        // Fill bank1, then both locked
        for (int i = 0; i < DEPTH; i++) begin
            do_write(TAG_W'(i), 3'(4 + i));
        end
        chk("b1_lock", 32'(mem1_lock), 32'd1);
        chk("wait_state", 32'(dut.state), 32'(WRWAIT));
        in_vld = 1'b1;
        #1;
        chk("wait_in_rdy", 32'(in_rdy), 32'd0);
        chk("wait_wr_en", 32'(wr_en), 32'd0);
        in_vld = 1'b0;

        // Drain bank0
        for (int i = 0; i < DEPTH; i++) begin
            do_pop(1'b0, 3'(i));
        end
        chk("drain0_lock", 32'(mem0_lock), 32'd0);
        chk("drain0_empty", 32'(mem0_empty), 32'd1);
        chk("drain0_still_wait", 32'(dut.state), 32'(WRWAIT));
        chk("drain0_rd_ptr", 32'(dut.rd_ptr), 32'd0);
        tick();
        chk("resume_state", 32'(dut.state), 32'(WR0));
        chk("resume_in_rdy", 32'(in_rdy), 32'd1);

        // Drain bank1
        for (int i = 0; i < DEPTH; i++) begin
            do_pop(1'b1, 3'(4 + i));
        end
        chk("drain1_lock", 32'(mem1_lock), 32'd0);

        // Duplicate tag into bank0
        do_write(2'd1, 3'd1);
        in_vld = 1'b1;
        in_tag = 2'd1;
        #1;
        chk("dup_in_rdy", 32'(in_rdy), 32'd1);
`ifdef WR_DUP_CHECK_EN
        chk("dup_wr_en", 32'(wr_en), 32'd0);
        tick();
        in_vld = 1'b0;
        chk("dup_err_pulse", 32'(err_dup), 32'd1);
`else
        chk("dup_wr_en", 32'(wr_en), 32'd1);
        tick();
        in_vld = 1'b0;
        chk("dup_err_tied", 32'(err_dup), 32'd0);
`endif
        do_write(2'd0, 3'd0);
        chk("dup_err_clear", 32'(err_dup), 32'd0);
        do_write(2'd2, 3'd2);
        chk("dup_lock_pending", 32'(mem0_lock), 32'd0);
        do_write(2'd3, 3'd3);
        chk("dup_lock_done", 32'(mem0_lock), 32'd1);
        chk("dup_state_wr1", 32'(dut.state), 32'(WR1));

        // Bank1 fill racing bank0 drain; last write and last pop coincide
        for (int i = 0; i < DEPTH; i++) begin
            in_vld           = 1'b1;
            in_tag           = TAG_W'(i);
            rd_en            = 1'b1;
            mem0rd_st_decode = 1'b1;
            #1;
            chk("race_wr_en", 32'(wr_en), 32'd1);
            chk("race_wr_addr", 32'(wr_addr), 32'(4 + i));
            chk("race_rd_fire", 32'(rd_fire), 32'd1);
            chk("race_rd_addr", 32'(rd_addr), 32'(i));
            tick();
        end
        in_vld           = 1'b0;
        rd_en            = 1'b0;
        mem0rd_st_decode = 1'b0;
        chk("race_state_wr0", 32'(dut.state), 32'(WR0));
        chk("race_lock0", 32'(mem0_lock), 32'd0);
        chk("race_lock1", 32'(mem1_lock), 32'd1);
        chk("race_in_rdy", 32'(in_rdy), 32'd1);

        // Reset with bank0 locked and bank1 half filled
        for (int i = 0; i < DEPTH; i++) begin
            do_pop(1'b1, 3'(4 + i));
        end
        for (int i = 0; i < DEPTH; i++) begin
            do_write(TAG_W'(i), 3'(i));
        end
        do_write(2'd0, 3'd4);
        do_write(2'd1, 3'd5);
        chk("pre_rst_lock0", 32'(mem0_lock), 32'd1);
        rst_n  = 1'b0;
        in_vld = 1'b1;
        #1;
        chk("mid_rst_in_rdy", 32'(in_rdy), 32'd0);
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        tick();
        chk("mid_rst_lock0", 32'(mem0_lock), 32'd0);
        chk("mid_rst_lock1", 32'(mem1_lock), 32'd0);
        chk("mid_rst_empty0", 32'(mem0_empty), 32'd1);
        chk("mid_rst_empty1", 32'(mem1_empty), 32'd1);
        chk("mid_rst_state", 32'(dut.state), 32'(WR0));
        rst_n  = 1'b1;
        in_vld = 1'b0;
        tick();
        chk("post_rst_in_rdy", 32'(in_rdy), 32'd1);
        do_write(2'd0, 3'd0);
        chk("post_rst_lock0", 32'(mem0_lock), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
